// File: rtl/bce_pkg.sv
// Shared definitions for the branch condition evaluator: operand width and
// the branch-function code enumeration.
package bce_pkg;

  localparam int BCE_W = 32;

  typedef enum logic [3:0] {
    BF_LTZ    = 4'd0,
    BF_GEZ    = 4'd1,
    BF_EQ     = 4'd2,
    BF_NE     = 4'd3,
    BF_LEZ    = 4'd4,
    BF_GTZ    = 4'd5,
    BF_LT     = 4'd6,
    BF_GE     = 4'd7,
    BF_LTU    = 4'd8,
    BF_GEU    = 4'd9,
    BF_ALWAYS = 4'd10
  } bf_e;

endpackage

// File: rtl/bce_compare.sv
// Combinational branch condition: the primitive compare results are formed
// once and then selected by the branch-function code.
module bce_compare
  import bce_pkg::*;
#(
  parameter int W = BCE_W
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [3:0]   bf,
  output logic         cond,
  output logic         illegal
);

  logic signed [W-1:0] a_s;
  logic signed [W-1:0] b_s;
  logic                eq;
  logic                a_neg;
  logic                a_zero;
  logic                lt_s;
  logic                lt_u;

  assign a_s    = a;
  assign b_s    = b;
  assign eq     = (a == b);
  assign a_neg  = a[W-1];
  assign a_zero = (a == '0);
  // Native signed/unsigned relational compares are exact over the full range.
  assign lt_s   = (a_s < b_s);
  assign lt_u   = (a < b);

  always_comb begin
    cond    = 1'b0;
    illegal = 1'b0;
    case (bf_e'(bf))
      BF_LTZ:    cond = a_neg;
      BF_GEZ:    cond = ~a_neg;
      BF_EQ:     cond = eq;
      BF_NE:     cond = ~eq;
      BF_LEZ:    cond = a_neg | a_zero;
      BF_GTZ:    cond = ~a_neg & ~a_zero;
      BF_LT:     cond = lt_s;
      BF_GE:     cond = ~lt_s;
      BF_LTU:    cond = lt_u;
      BF_GEU:    cond = ~lt_u;
      BF_ALWAYS: cond = 1'b1;
      default:   illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/branch_cond_eval.sv
// Branch condition evaluator: combinational compare followed by a single
// output register stage; results appear one cycle after a valid request.
module branch_cond_eval
  import bce_pkg::*;
#(
  parameter int W = BCE_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [3:0]   bf,
  output logic         bcres,
  output logic         out_valid,
  output logic         bf_illegal
);

  logic cond_p0;
  logic illegal_p0;
  logic bcres_p1;
  logic illegal_p1;
  logic vld_p1;

  bce_compare #(.W(W)) u_compare (
    .a       (a),
    .b       (b),
    .bf      (bf),
    .cond    (cond_p0),
    .illegal (illegal_p0)
  );

  // p0 -> p1: result and flag only update on a captured request
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1     <= 1'b0;
      bcres_p1   <= 1'b0;
      illegal_p1 <= 1'b0;
    end else begin
      vld_p1 <= in_valid;
      if (in_valid) begin
        bcres_p1   <= cond_p0;
        illegal_p1 <= illegal_p0;
      end
    end
  end

  assign bcres      = bcres_p1;
  assign out_valid  = vld_p1;
  assign bf_illegal = illegal_p1;

endmodule

// File: tb/tb_branch_cond_eval.sv
// Self-checking bench for branch_cond_eval: directed spec vectors plus
// randomized requests checked against a behavioural model.
module tb_branch_cond_eval;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [31:0] a;
  logic [31:0] b;
  logic [3:0]  bf;
  logic        bcres;
  logic        out_valid;
  logic        bf_illegal;

  int checks;
  int errors;

  branch_cond_eval #(.W(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .a          (a),
    .b          (b),
    .bf         (bf),
    .bcres      (bcres),
    .out_valid  (out_valid),
    .bf_illegal (bf_illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: decode rules evaluated with wide integer arithmetic.
  function automatic void model(input logic [31:0] x, input logic [31:0] y,
                                input logic [3:0] f, output logic t, output logic il);
    longint sx, sy, ux, uy;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    ux = longint'({32'd0, x});
    uy = longint'({32'd0, y});
    il = 1'b0;
    t  = 1'b0;
    case (f)
      4'd0:  t = (sx < 0);
      4'd1:  t = (sx >= 0);
      4'd2:  t = (ux == uy);
      4'd3:  t = (ux != uy);
      4'd4:  t = (sx <= 0);
      4'd5:  t = (sx > 0);
      4'd6:  t = (sx < sy);
      4'd7:  t = (sx >= sy);
      4'd8:  t = (ux < uy);
      4'd9:  t = (ux >= uy);
      4'd10: t = 1'b1;
      default: il = 1'b1;
    endcase
  endfunction

  // Apply one request at a falling edge; outputs are observed at the next falling edge.
  task automatic drive(input logic v, input logic [31:0] aa, input logic [31:0] bb,
                       input logic [3:0] f);
    in_valid = v;
    a        = aa;
    b        = bb;
    bf       = f;
    @(negedge clk);
  endtask

  task automatic test_reset;
    checks++;
    if (bcres !== 1'b0 || out_valid !== 1'b0 || bf_illegal !== 1'b0) begin
      errors++;
      $display("FAIL reset_state got bcres=%b out_valid=%b bf_illegal=%b want 0 0 0",
               bcres, out_valid, bf_illegal);
    end
  endtask

  task automatic test_zero_codes;
    logic [3:0] codes [6] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5};
    logic       exp   [6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 32'd1, 32'd1, codes[i]);
      checks++;
      if (bcres !== exp[i] || out_valid !== 1'b1 || bf_illegal !== 1'b0) begin
        errors++;
        $display("FAIL zero_codes bf=%0d got bcres=%b vld=%b ill=%b want %b 1 0",
                 codes[i], bcres, out_valid, bf_illegal, exp[i]);
      end
    end
  endtask

  task automatic test_boundaries;
    logic [31:0] av [12] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF,
                             32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 32'h0, 32'h0,
                             32'h80000000, 32'h80000000, 32'h80000000};
    logic [31:0] bv [12] = '{32'd2, 32'd2, 32'd2, 32'd2, 32'd2, 32'd2,
                             32'd5, 32'd5, 32'd5,
                             32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF};
    logic [3:0]  fv [12] = '{4'd0, 4'd2, 4'd6, 4'd8, 4'd9, 4'd5,
                             4'd4, 4'd5, 4'd1, 4'd6, 4'd7, 4'd8};
    logic        ev [12] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0,
                             1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 12; i++) begin
      drive(1'b1, av[i], bv[i], fv[i]);
      checks++;
      if (bcres !== ev[i] || out_valid !== 1'b1 || bf_illegal !== 1'b0) begin
        errors++;
        $display("FAIL boundary a=%h b=%h bf=%0d got bcres=%b vld=%b ill=%b want %b 1 0",
                 av[i], bv[i], fv[i], bcres, out_valid, bf_illegal, ev[i]);
      end
    end
  endtask

  task automatic test_reserved_always;
    for (int f = 11; f < 16; f++) begin
      drive(1'b1, $urandom, $urandom, 4'(f));
      checks++;
      if (bcres !== 1'b0 || bf_illegal !== 1'b1 || out_valid !== 1'b1) begin
        errors++;
        $display("FAIL reserved bf=%0d got bcres=%b ill=%b vld=%b want 0 1 1",
                 f, bcres, bf_illegal, out_valid);
      end
    end
    drive(1'b1, $urandom, $urandom, 4'd10);
    checks++;
    if (bcres !== 1'b1 || bf_illegal !== 1'b0 || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL always got bcres=%b ill=%b vld=%b want 1 0 1", bcres, bf_illegal, out_valid);
    end
  endtask

  task automatic test_valid_gating;
    logic t, il;
    logic [31:0] aa, bb;
    logic [3:0]  f;
    // Pick a request whose result is 1 so a spurious reload of 0 is visible.
    aa = 32'h80000000;
    bb = 32'h1;
    f  = 4'd6;
    model(aa, bb, f, t, il);
    drive(1'b1, aa, bb, f);
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, $urandom, $urandom, 4'($urandom_range(0, 15)));
      checks++;
      if (out_valid !== 1'b0 || bcres !== t || bf_illegal !== il) begin
        errors++;
        $display("FAIL valid_gating cyc=%0d got vld=%b bcres=%b ill=%b want 0 %b %b",
                 i, out_valid, bcres, bf_illegal, t, il);
      end
    end
  endtask

  task automatic test_back_to_back_random;
    logic t, il;
    logic [31:0] aa, bb;
    logic [3:0]  f;
    logic        lt, lil;
    lt  = bcres;
    lil = bf_illegal;
    for (int i = 0; i < 300; i++) begin
      aa = $urandom;
      bb = ($urandom_range(0, 3) == 0) ? aa : 32'($urandom);
      case ($urandom_range(0, 3))
        0: aa = 32'h0;
        1: aa = 32'h80000000;
        default: ;
      endcase
      f = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 4) == 0) begin
        drive(1'b0, aa, bb, f);
        checks++;
        if (out_valid !== 1'b0 || bcres !== lt || bf_illegal !== lil) begin
          errors++;
          $display("FAIL random_idle i=%0d got vld=%b bcres=%b ill=%b want 0 %b %b",
                   i, out_valid, bcres, bf_illegal, lt, lil);
        end
      end else begin
        model(aa, bb, f, t, il);
        drive(1'b1, aa, bb, f);
        checks++;
        if (out_valid !== 1'b1 || bcres !== t || bf_illegal !== il) begin
          errors++;
          $display("FAIL random i=%0d a=%h b=%h bf=%0d got vld=%b bcres=%b ill=%b want 1 %b %b",
                   i, aa, bb, f, out_valid, bcres, bf_illegal, t, il);
        end
        lt  = t;
        lil = il;
      end
    end
  endtask

  task automatic test_async_reset;
    drive(1'b1, 32'd7, 32'd9, 4'd10);
    checks++;
    if (bcres !== 1'b1 || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset got bcres=%b vld=%b want 1 1", bcres, out_valid);
    end
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (bcres !== 1'b0 || out_valid !== 1'b0 || bf_illegal !== 1'b0) begin
      errors++;
      $display("FAIL async_reset got bcres=%b vld=%b ill=%b want 0 0 0",
               bcres, out_valid, bf_illegal);
    end
    @(negedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    rst_n    = 1'b1;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || bcres !== 1'b0 || bf_illegal !== 1'b0) begin
      errors++;
      $display("FAIL post_reset got vld=%b bcres=%b ill=%b want 0 0 0",
               out_valid, bcres, bf_illegal);
    end
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    a        = '0;
    b        = '0;
    bf       = '0;
    @(negedge clk);
    @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    @(negedge clk);
    test_reset();
    test_zero_codes();
    test_boundaries();
    test_reserved_always();
    test_valid_gating();
    test_back_to_back_random();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
